// File: rtl/sw_fifo_in.sv
// sw_fifo_in: switch synchroniser, edge-detected push/pop/clear events and 16-entry byte FIFO.
// Define SW_FIFO_DEBOUNCE_EN to debounce the control switches for DEBOUNCE_CYCLES cycles.
module sw_fifo_in #(
    parameter int DATA_W          = 8,
    parameter int DEPTH_LOG2      = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           sw,
    output logic [DATA_W-1:0]     dout,
    output logic                  dout_valid,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  ovf,
    output logic                  udf
);
    localparam logic [DEPTH_LOG2:0] FULL_C = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);

    logic [10:0]             s1_q, s2_q;
    logic [2:0]              filt, hist_q, ev;
    logic [DEPTH_LOG2-1:0]   wp_q, wp_d, rp_q, rp_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic [DATA_W-1:0]       dout_q, dout_d;
    logic                    dv_q, dv_d, ovf_q, ovf_d, udf_q, udf_d;
    logic                    do_push, do_pop;
    logic [DATA_W-1:0]       mem_q [2**DEPTH_LOG2];
    logic                    unused_sw;

    assign unused_sw = ^sw[15:11];

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= sw[10:0];
            s2_q <= s1_q;
        end
    end

`ifdef SW_FIFO_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];
    logic [2:0]    filt_q, filt_d;

    // counter runs only while the synchronised level disagrees with the accepted one
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (s2_q[8+i] != filt_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES-1))
                    filt_d[i] = s2_q[8+i];
                else
                    cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            filt_q <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            filt_q <= filt_d;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign filt = filt_q;
`else
    assign filt = s2_q[10:8];
`endif

    assign ev = filt & ~hist_q;

    // a pop frees the slot a same-cycle push needs when full
    assign do_pop  = ev[1] && (count_q != '0);
    assign do_push = ev[0] && ((count_q != FULL_C) || do_pop);

    always_comb begin
        wp_d    = do_push ? wp_q + 1'b1 : wp_q;
        rp_d    = do_pop  ? rp_q + 1'b1 : rp_q;
        count_d = (do_push == do_pop) ? count_q : (do_push ? count_q + 1'b1 : count_q - 1'b1);
        dout_d  = do_pop ? mem_q[rp_q] : dout_q;
        dv_d    = do_pop;
        ovf_d   = (ev[0] && !do_push) || (ovf_q && !ev[2]);
        udf_d   = (ev[1] && !do_pop) || (udf_q && !ev[2]);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hist_q  <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            hist_q  <= filt;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && do_push) mem_q[wp_q] <= s2_q[DATA_W-1:0];
    end

    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign count      = count_q;
    assign full       = (count_q == FULL_C);
    assign empty      = (count_q == '0);
    assign ovf        = ovf_q;
    assign udf        = udf_q;
endmodule

// File: tb/tb_sw_fifo_in.sv
// tb_sw_fifo_in: directed switch sequences; popped bytes checked by a scoreboard monitor.
module tb_sw_fifo_in;
    localparam int DEB = 8;
`ifdef SW_FIFO_DEBOUNCE_EN
    localparam int LAT  = 3 + DEB;
    localparam int HOLD = DEB + 6;
`else
    localparam int LAT  = 3;
    localparam int HOLD = 4;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] sw  = '0;
    logic [7:0]  dout;
    logic        dout_valid, full, empty, ovf, udf;
    logic [4:0]  count;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  e;
    int          c0, n;

    sw_fifo_in #(.DATA_W(8), .DEPTH_LOG2(4), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .sw(sw), .dout(dout), .dout_valid(dout_valid),
        .count(count), .full(full), .empty(empty), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && dout_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: dout=0x%0h with no pop pending", dout);
            end else begin
                e = exp_q.pop_front();
                if (dout !== e) begin
                    bad++;
                    $display("FAIL pop_data: got 0x%0h expected 0x%0h", dout, e);
                end
            end
        end
    end

    task automatic op(input logic [2:0] ctl, input logic [7:0] d,
                      input bit lat = 0, input int cb = 0, input int ca = 0);
        @(negedge clk);
        sw[7:0] = d;
        repeat (3) @(negedge clk);
        sw[10:8] = ctl;
        if (lat) begin
            repeat (LAT-1) @(posedge clk);
            #1 chk("lat_before", int'(count), cb);
            @(posedge clk);
            #1 chk("lat_at", int'(count), ca);
        end
        repeat (HOLD) @(negedge clk);
        sw[10:8] = '0;
        repeat (HOLD) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_dout", int'(dout), 0);
        chk("rst_dv", int'(dout_valid), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_udf", int'(udf), 0);
        rst = 1'b1;

        op(3'b001, 8'hA5, 1, 0, 1);
        op(3'b001, 8'h3C);
        chk("two_count", int'(count), 2);
        exp_q.push_back(8'hA5);
        op(3'b010, 8'h00, 1, 2, 1);
        exp_q.push_back(8'h3C);
        op(3'b010, 8'h00);
        chk("drain_count", int'(count), 0);
        chk("drain_empty", int'(empty), 1);
        chk("drain_dout", int'(dout), 8'h3C);

        for (int i = 0; i < 16; i++) op(3'b001, 8'(i));
        chk("fill_count", int'(count), 16);
        chk("fill_full", int'(full), 1);
        chk("fill_ovf", int'(ovf), 0);
        op(3'b001, 8'h10);
        chk("ovf_set", int'(ovf), 1);
        chk("ovf_count", int'(count), 16);
        op(3'b100, 8'h00);
        chk("ovf_clear", int'(ovf), 0);

        exp_q.push_back(8'h00);
        op(3'b011, 8'h77);
        chk("fullpp_count", int'(count), 16);
        chk("fullpp_ovf", int'(ovf), 0);
        chk("fullpp_dout", int'(dout), 8'h00);

        for (int i = 1; i < 16; i++) begin
            exp_q.push_back(8'(i));
            op(3'b010, 8'h00);
        end
        exp_q.push_back(8'h77);
        op(3'b010, 8'h00);
        chk("wrap_empty", int'(empty), 1);
        op(3'b010, 8'h00);
        chk("udf_set", int'(udf), 1);
        chk("udf_dout", int'(dout), 8'h77);
        chk("udf_count", int'(count), 0);
        op(3'b100, 8'h00);
        chk("udf_clear", int'(udf), 0);

        op(3'b011, 8'h55);
        chk("emptypp_count", int'(count), 1);
        chk("emptypp_udf", int'(udf), 1);
        op(3'b100, 8'h00);
        chk("clear_udf", int'(udf), 0);
        chk("clear_ovf", int'(ovf), 0);

        for (int i = 0; i < 4; i++) op(3'b001, 8'(8'h20 + i));
        chk("pre_rst_count", int'(count), 5);
        @(negedge clk);
        sw[8] = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_count", int'(count), 0);
        chk("midrst_empty", int'(empty), 1);
        rst = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        chk("held_push_count", int'(count), 1);
        sw[8] = 1'b0;
        repeat (HOLD) @(negedge clk);
        chk("held_push_once", int'(count), 1);

`ifdef SW_FIFO_DEBOUNCE_EN
        c0 = int'(count);
        sw[8] = 1'b1;
        repeat (5) @(negedge clk);
        sw[8] = 1'b0;
        repeat (20) @(negedge clk);
        chk("glitch_count", int'(count), c0);
        sw[8] = 1'b1;
        n = 0;
        while (int'(count) == c0 && n < 30) begin
            @(posedge clk);
            #1 n++;
        end
        chk("deb_latency_edges", n, LAT);
        repeat (2) @(negedge clk);
        sw[8] = 1'b0;
        repeat (20) @(negedge clk);
        chk("deb_count", int'(count), c0 + 1);
`endif

        chk("pending_pops", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
